// File: rtl/rom_dl_router_if.sv
// Signal bundle between hps_io ioctl, the ROM download router and the per-region ROM stores.
interface rom_dl_router_if #(
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 25
);
  logic            ioctl_download;
  logic [7:0]      ioctl_index;
  logic            ioctl_wr;
  logic [AW-1:0]   ioctl_addr;
  logic [7:0]      ioctl_dout;
  logic            ioctl_wait;
  logic [AW-1:0]   out_addr;
  logic [7:0]      out_data;
  logic [NREG-1:0] rgn_we;
  logic [NREG-1:0] rgn_req;
  logic [NREG-1:0] rgn_ack;
  logic            loaded;
  logic            oob;
  logic            ovf;

  // master: hps_io plus ROM stores; slave: the router
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rgn_ack,
    input  ioctl_wait, out_addr, out_data, rgn_we, rgn_req, loaded, oob, ovf
  );
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rgn_ack,
    output ioctl_wait, out_addr, out_data, rgn_we, rgn_req, loaded, oob, ovf
  );
endinterface

// File: rtl/rom_dl_router.sv
// ROM download router: decodes ioctl bytes into regions, rebases the address and
// delivers each byte as a BRAM strobe or a toggle req/ack transfer, with a one-entry skid.
module rom_dl_router #(
  parameter int unsigned        NREG   = 4,
  parameter int unsigned        AW     = 25,
  parameter logic [7:0]         INDEX  = 8'd0,
  parameter logic [NREG*AW-1:0] BASE   = {25'h32000, 25'h12000, 25'h0E000, 25'h00000},
  parameter logic [NREG*AW-1:0] SIZE   = {25'h08000, 25'h20000, 25'h04000, 25'h0E000},
  parameter logic [NREG-1:0]    HSMASK = 4'b0110
) (
  input logic            clk_sys,
  input logic            reset,
  rom_dl_router_if.slave bus
);
  localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [0:0] {IDLE, WAIT_ACK} state_t;

  state_t          state, state_d;
  logic [RW-1:0]   cur, cur_d;
  logic            skid_vld, skid_vld_d;
  logic [AW-1:0]   skid_off, skid_off_d;
  logic [7:0]      skid_data, skid_data_d;
  logic [RW-1:0]   skid_rgn, skid_rgn_d;
  logic [AW-1:0]   out_addr_q, out_addr_d;
  logic [7:0]      out_data_q, out_data_d;
  logic [NREG-1:0] we_q, we_d;
  logic [NREG-1:0] req_q, req_d;
  logic            wait_q, wait_d;
  logic            loaded_q, loaded_d;
  logic            oob_q, oob_d;
  logic            ovf_q, ovf_d;
  logic            dl_q;
  logic            seen_q, seen_d;

  logic            dl_act, acc, acc_hit, dl_rise, free;
  logic            in_hit;
  logic [RW-1:0]   in_rgn;
  logic [AW-1:0]   in_off;
  logic [AW:0]     lo, hi, a_ext;
  logic            iss, push;
  logic [RW-1:0]   iss_rgn;
  logic [AW-1:0]   iss_off;
  logic [7:0]      iss_data;

  assign dl_act  = bus.ioctl_download && (bus.ioctl_index == INDEX);
  assign acc     = dl_act && bus.ioctl_wr;
  assign acc_hit = acc && in_hit;
  assign dl_rise = dl_act && !dl_q;

  // Lowest matching region wins; AW+1-bit bounds so BASE+SIZE cannot wrap
  always_comb begin
    in_hit = 1'b0;
    in_rgn = '0;
    in_off = '0;
    lo     = '0;
    hi     = '0;
    a_ext  = {1'b0, bus.ioctl_addr};
    for (int i = 0; i < int'(NREG); i++) begin
      lo = {1'b0, BASE[i*AW +: AW]};
      hi = lo + {1'b0, SIZE[i*AW +: AW]};
      if (!in_hit && (a_ext >= lo) && (a_ext < hi)) begin
        in_hit = 1'b1;
        in_rgn = RW'(i);
        in_off = bus.ioctl_addr - BASE[i*AW +: AW];
      end
    end
  end

  always_comb begin
    state_d     = state;
    cur_d       = cur;
    skid_vld_d  = skid_vld;
    skid_off_d  = skid_off;
    skid_data_d = skid_data;
    skid_rgn_d  = skid_rgn;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    we_d        = '0;
    req_d       = req_q;
    loaded_d    = loaded_q;
    oob_d       = oob_q;
    ovf_d       = ovf_q;
    seen_d      = seen_q;
    iss         = 1'b0;
    push        = 1'b0;
    iss_rgn     = in_rgn;
    iss_off     = in_off;
    iss_data    = bus.ioctl_dout;
    free        = (state == IDLE) || (bus.rgn_ack[cur] == req_q[cur]);

    if (dl_rise) begin
      seen_d   = 1'b1;
      loaded_d = 1'b0;
      oob_d    = 1'b0;
      ovf_d    = 1'b0;
    end
    if (acc && !in_hit) oob_d = 1'b1;

    // The skid entry always goes ahead of a fresh byte to keep order
    if (free && skid_vld) begin
      iss        = 1'b1;
      iss_rgn    = skid_rgn;
      iss_off    = skid_off;
      iss_data   = skid_data;
      skid_vld_d = 1'b0;
      push       = acc_hit;
    end else if (state == IDLE) begin
      iss = acc_hit;
    end else if (free) begin
      state_d = IDLE;
      push    = acc_hit;
    end else if (acc_hit) begin
      if (skid_vld) ovf_d = 1'b1;
      else          push  = 1'b1;
    end

    if (push) begin
      skid_vld_d  = 1'b1;
      skid_off_d  = in_off;
      skid_data_d = bus.ioctl_dout;
      skid_rgn_d  = in_rgn;
    end

    if (iss) begin
      out_addr_d = iss_off;
      out_data_d = iss_data;
      if (HSMASK[iss_rgn]) begin
        req_d[iss_rgn] = ~req_q[iss_rgn];
        cur_d          = iss_rgn;
        state_d        = WAIT_ACK;
      end else begin
        we_d[iss_rgn] = 1'b1;
        state_d       = IDLE;
      end
    end

    wait_d = (state_d == WAIT_ACK);

    // loaded waits for the download to fall and every byte to drain
    if (seen_d && !dl_act && (state_d == IDLE) && !skid_vld_d) begin
      loaded_d = 1'b1;
      seen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      skid_vld   <= 1'b0;
      skid_off   <= '0;
      skid_data  <= '0;
      skid_rgn   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      we_q       <= '0;
      req_q      <= '0;
      wait_q     <= 1'b0;
      loaded_q   <= 1'b0;
      oob_q      <= 1'b0;
      ovf_q      <= 1'b0;
      dl_q       <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state      <= state_d;
      cur        <= cur_d;
      skid_vld   <= skid_vld_d;
      skid_off   <= skid_off_d;
      skid_data  <= skid_data_d;
      skid_rgn   <= skid_rgn_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      we_q       <= we_d;
      req_q      <= req_d;
      wait_q     <= wait_d;
      loaded_q   <= loaded_d;
      oob_q      <= oob_d;
      ovf_q      <= ovf_d;
      dl_q       <= dl_act;
      seen_q     <= seen_d;
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_data   = out_data_q;
  assign bus.rgn_we     = we_q;
  assign bus.rgn_req    = req_q;
  assign bus.loaded     = loaded_q;
  assign bus.oob        = oob_q;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: queue-based transaction model checked every cycle plus literal checks.
module tb_rom_dl_router;
  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 25;

  logic clk_sys = 1'b0;
  logic reset   = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  rom_dl_router_if #(.NREG(NREG), .AW(AW)) bus ();

  rom_dl_router dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // Region map written out independently of the packed parameters
  int unsigned base_a [NREG] = '{32'h00000, 32'h0E000, 32'h12000, 32'h32000};
  int unsigned size_a [NREG] = '{32'h0E000, 32'h04000, 32'h20000, 32'h08000};
  bit          hs_a   [NREG] = '{1'b0, 1'b1, 1'b1, 1'b0};

  typedef struct {
    int unsigned rgn;
    int unsigned off;
    logic [7:0]  data;
  } ent_t;

  ent_t        q[$];
  bit          busy = 1'b0;
  int unsigned cur  = 0;
  bit          dl_prev = 1'b0;
  bit          seen = 1'b0;
  logic [AW-1:0]   exp_addr = '0;
  logic [7:0]      exp_data = '0;
  logic [NREG-1:0] exp_we = '0;
  logic [NREG-1:0] exp_req = '0;
  logic exp_wait = 1'b0, exp_loaded = 1'b0, exp_oob = 1'b0, exp_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, want);
    end
  endtask

  task automatic issue(input ent_t e);
    exp_addr = AW'(e.off);
    exp_data = e.data;
    if (hs_a[e.rgn]) begin
      exp_req[e.rgn] = ~exp_req[e.rgn];
      busy = 1'b1;
      cur  = e.rgn;
    end else begin
      exp_we[e.rgn] = 1'b1;
      busy = 1'b0;
    end
  endtask

  task automatic model_step();
    bit dl_act, acc, hit, inc, ackd;
    ent_t nw, e;
    int unsigned a;
    dl_act = bus.ioctl_download && (bus.ioctl_index == 8'd0);
    acc    = dl_act && bus.ioctl_wr;
    exp_we = '0;
    if (dl_act && !dl_prev) begin
      seen = 1'b1; exp_loaded = 1'b0; exp_oob = 1'b0; exp_ovf = 1'b0;
    end
    dl_prev = dl_act;
    a   = 32'(bus.ioctl_addr);
    hit = 1'b0;
    nw  = '{rgn: 0, off: 0, data: bus.ioctl_dout};
    for (int i = 0; i < int'(NREG); i++)
      if (!hit && a >= base_a[i] && a < base_a[i] + size_a[i]) begin
        hit = 1'b1; nw.rgn = i; nw.off = a - base_a[i];
      end
    if (acc && !hit) exp_oob = 1'b1;
    inc  = acc && hit;
    ackd = busy && (bus.rgn_ack[cur] == exp_req[cur]);
    if (!busy || ackd) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        if (inc) q.push_back(nw);
        issue(e);
      end else if (!busy) begin
        if (inc) issue(nw);
      end else begin
        busy = 1'b0;
        if (inc) q.push_back(nw);
      end
    end else if (inc) begin
      if (q.size() >= 1) exp_ovf = 1'b1;
      else q.push_back(nw);
    end
    exp_wait = busy;
    if (seen && !dl_act && !busy && q.size() == 0) begin
      exp_loaded = 1'b1; seen = 1'b0;
    end
  endtask

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      q.delete();
      busy = 1'b0; cur = 0; dl_prev = 1'b0; seen = 1'b0;
      exp_addr = '0; exp_data = '0; exp_we = '0; exp_req = '0;
      exp_wait = 1'b0; exp_loaded = 1'b0; exp_oob = 1'b0; exp_ovf = 1'b0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk_sys) begin
    chk("ioctl_wait", 32'(bus.ioctl_wait), 32'(exp_wait));
    chk("out_addr",   32'(bus.out_addr),   32'(exp_addr));
    chk("out_data",   32'(bus.out_data),   32'(exp_data));
    chk("rgn_we",     32'(bus.rgn_we),     32'(exp_we));
    chk("rgn_req",    32'(bus.rgn_req),    32'(exp_req));
    chk("loaded",     32'(bus.loaded),     32'(exp_loaded));
    chk("oob",        32'(bus.oob),        32'(exp_oob));
    chk("ovf",        32'(bus.ovf),        32'(exp_ovf));
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [7:0] data);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    cyc();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wait"},   32'(bus.ioctl_wait), 32'd0);
    chk({tag, "_req"},    32'(bus.rgn_req),    32'd0);
    chk({tag, "_we"},     32'(bus.rgn_we),     32'd0);
    chk({tag, "_loaded"}, 32'(bus.loaded),     32'd0);
    chk({tag, "_oob"},    32'(bus.oob),        32'd0);
    chk({tag, "_ovf"},    32'(bus.ovf),        32'd0);
    chk({tag, "_addr"},   32'(bus.out_addr),   32'd0);
    chk({tag, "_data"},   32'(bus.out_data),   32'd0);
  endtask

  task automatic direct_a5(input string tag);
    wr(25'h00005, 8'hA5);
    chk({tag, "_we"},   32'(bus.rgn_we),     32'h1);
    chk({tag, "_addr"}, 32'(bus.out_addr),   32'h5);
    chk({tag, "_data"}, 32'(bus.out_data),   32'hA5);
    chk({tag, "_wait"}, 32'(bus.ioctl_wait), 32'h0);
    cyc();
    chk({tag, "_we_1cyc"}, 32'(bus.rgn_we), 32'h0);
  endtask

  initial begin
    int wh;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.rgn_ack        = '0;
    #1 reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    chk_all_zero("reset");
    bus.ioctl_download = 1'b1;
    cyc();

    direct_a5("direct");

    // Handshake region 2 with a 7-cycle stall
    wr(25'h12010, 8'h3C);
    chk("hs_req",  32'(bus.rgn_req),    32'h4);
    chk("hs_addr", 32'(bus.out_addr),   32'h10);
    chk("hs_data", 32'(bus.out_data),   32'h3C);
    wh = bus.ioctl_wait ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.ioctl_wait) wh++;
      chk("hs_hold_addr", 32'(bus.out_addr), 32'h10);
    end
    bus.rgn_ack[2] = 1'b1;
    cyc();
    chk("hs_wait_drop", 32'(bus.ioctl_wait), 32'h0);
    chk("hs_wait_cycles", 32'(wh), 32'd7);

    // Skid fill then overflow while waiting on region 2
    wr(25'h12020, 8'h11);
    chk("sk_req0", 32'(bus.rgn_req), 32'h0);
    wr(25'h0E001, 8'h22);
    wr(25'h0E002, 8'h33);
    chk("sk_ovf",  32'(bus.ovf),     32'h1);
    chk("sk_req1", 32'(bus.rgn_req), 32'h0);
    bus.rgn_ack[2] = 1'b0;
    cyc();
    chk("sk_req_r1", 32'(bus.rgn_req),    32'h2);
    chk("sk_addr",   32'(bus.out_addr),   32'h1);
    chk("sk_data",   32'(bus.out_data),   32'h22);
    chk("sk_wait",   32'(bus.ioctl_wait), 32'h1);
    bus.rgn_ack[1] = 1'b1;
    cyc();
    chk("sk_idle", 32'(bus.ioctl_wait), 32'h0);

    // Out of range, foreign index, region boundaries
    wr(25'h3A000, 8'h44);
    chk("oob_flag", 32'(bus.oob),     32'h1);
    chk("oob_we",   32'(bus.rgn_we),  32'h0);
    chk("oob_req",  32'(bus.rgn_req), 32'h2);
    bus.ioctl_index = 8'd1;
    wr(25'h00005, 8'h55);
    chk("idx_we", 32'(bus.rgn_we), 32'h0);
    bus.ioctl_index = 8'd0;
    cyc();
    wr(25'h0DFFF, 8'h66);
    chk("bnd0_we",   32'(bus.rgn_we),   32'h1);
    chk("bnd0_addr", 32'(bus.out_addr), 32'hDFFF);
    wr(25'h39FFF, 8'h67);
    chk("bnd3_we",   32'(bus.rgn_we),   32'h8);
    chk("bnd3_addr", 32'(bus.out_addr), 32'h7FFF);

    // Back-to-back mix: direct byte queued behind a handshake byte
    wr(25'h00100, 8'hD1);
    wr(25'h0E010, 8'hD2);
    wr(25'h00200, 8'hD3);
    cyc(); cyc();
    bus.rgn_ack[1] = bus.rgn_req[1];
    cyc();
    chk("mix_we",   32'(bus.rgn_we),   32'h1);
    chk("mix_addr", 32'(bus.out_addr), 32'h200);
    cyc();

    // loaded deferred by a late drain, then cleared by a new download
    wr(25'h3A000, 8'h00);
    wr(25'h12000, 8'h70);
    wr(25'h0E020, 8'h71);
    wr(25'h0E021, 8'h72);
    chk("ld_ovf", 32'(bus.ovf), 32'h1);
    bus.ioctl_download = 1'b0;
    cyc(); cyc(); cyc();
    chk("ld_pending", 32'(bus.loaded), 32'h0);
    bus.rgn_ack[2] = 1'b1;
    cyc();
    chk("ld_still", 32'(bus.loaded),  32'h0);
    chk("ld_skid",  32'(bus.out_addr), 32'h20);
    bus.rgn_ack[1] = 1'b1;
    cyc();
    chk("ld_set", 32'(bus.loaded), 32'h1);
    bus.ioctl_download = 1'b1;
    cyc();
    chk("ld_clr",  32'(bus.loaded), 32'h0);
    chk("oob_clr", 32'(bus.oob),    32'h0);
    chk("ovf_clr", 32'(bus.ovf),    32'h0);

    // Asynchronous reset while waiting for an ack
    wr(25'h12004, 8'h77);
    chk("ar_wait", 32'(bus.ioctl_wait), 32'h1);
    #2 reset = 1'b1;
    bus.rgn_ack = '0;
    #1;
    chk_all_zero("areset");
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    direct_a5("post_reset");
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rom_dl_router.md
# rom_dl_router

Parameterised ROM-download router that sits between `hps_io` ioctl outputs and the per-region ROM stores of an arcade core. It decodes each downloaded byte into one of `NREG` address regions and rebases the address to that region. It delivers the byte either as a one-cycle write strobe (BRAM) or as a toggle req/ack transfer (SDRAM ports), applying `ioctl_wait` backpressure. It replaces hand-written offset subtraction and req toggling, and adds a skid buffer, an out-of-range/overflow error report and a `loaded` flag.

## Interface
- `NREG`, 4 — number of regions (1..8).
- `AW`, 25 — ioctl address width.
- `INDEX`, 8'd0 — `ioctl_index` value accepted; other indices are ignored.
- `BASE`, {25'h32000,25'h12000,25'h0E000,25'h00000} — packed `NREG*AW`, region *i* at bits [i*AW +: AW].
- `SIZE`, {25'h08000,25'h20000,25'h04000,25'h0E000} — packed `NREG*AW` byte lengths; a size of 0 disables the region.
- `HSMASK`, 4'b0110 — bit *i* = 1: region *i* uses toggle handshake; 0: direct strobe.

Ports:
- `clk_sys` in 1 — single clock.
- `reset` in 1 — asynchronous, active-high.
- `ioctl_download` in 1 — download active.
- `ioctl_index` in 8 — download index.
- `ioctl_wr` in 1 — byte-valid pulse.
- `ioctl_addr` in AW — byte address.
- `ioctl_dout` in 8 — byte data.
- `ioctl_wait` out 1 — registered stall request to `hps_io`.
- `out_addr` out AW — rebased address (`ioctl_addr - BASE[i]`), shared by all regions.
- `out_data` out 8 — byte, shared.
- `rgn_we` out NREG — one-cycle strobe, direct regions only.
- `rgn_req` out NREG — toggle request, handshake regions only.
- `rgn_ack` in NREG — consumer toggles to match `rgn_req` when the write is done.
- `loaded` out 1 — download finished and all transfers drained.
- `oob` out 1 — sticky: a byte matched no region.
- `ovf` out 1 — sticky: a byte arrived with the skid buffer full and was dropped.

## Operation
- Accepted write: `ioctl_download & ioctl_wr & (ioctl_index==INDEX)`.
- Region decode: the lowest *i* with `BASE[i] <= addr < BASE[i]+SIZE[i]`, using AW+1-bit compare so there is no wrap. No match sets `oob` and drops the byte.
- FSM states: IDLE, WAIT_ACK.
- IDLE, source byte available (skid entry first, else the incoming write):
  - Direct region: register addr/data and pulse `rgn_we[i]` next cycle. Stay in IDLE. Throughput is 1 byte/cycle.
  - Handshake region: register addr/data and toggle `rgn_req[i]` next cycle. Latch *i* as `cur`, go to WAIT_ACK, assert `ioctl_wait`.
- WAIT_ACK: outputs are held stable. On `rgn_ack[cur]==rgn_req[cur]`:
  - skid valid: issue the skid entry (same rules as IDLE) that cycle.
  - skid empty: go to IDLE and deassert `ioctl_wait`.
- Skid buffer: one entry (addr, data, region). An accepted write while in WAIT_ACK fills it. An accepted write while the skid is full sets `ovf` and drops the byte.
- `loaded`:
  - Cleared on the rising edge of an accepted download (`ioctl_download & index match`).
  - Set once the download has fallen, the FSM is in IDLE and the skid is empty. A late drain defers setting.
- `oob`/`ovf` are cleared only by `reset` or by the start of a new accepted download.
- Reset (async): IDLE, skid empty; `rgn_req`, `rgn_we`, `ioctl_wait`, `loaded`, `oob`, `ovf`, `out_addr`, `out_data` all 0. Consumers share the same `reset` so that `rgn_ack` also returns to 0.
- A reset mid-transfer abandons the byte with no replay.

## Timing
- Direct: `ioctl_wr` at cycle N → `out_addr`/`out_data` valid and `rgn_we[i]`=1 at N+1, for exactly one cycle.
- Handshake: `rgn_req[i]` toggles at N+1 and `ioctl_wait` rises at N+1. `out_*` is stable from N+1 until the cycle after the matching ack.
- Ack observed at cycle M:
  - skid empty: IDLE and `ioctl_wait`=0 at M+1.
  - skid valid: next `rgn_req` toggle at M+1.
- Simultaneous ack and new write in WAIT_ACK with the skid empty: the write goes to the skid and is issued at M+1.
- The download falling edge while in WAIT_ACK does not abort the transfer; `loaded` follows the drain.
- Mixed regions: a direct-region byte that arrives behind a pending handshake waits in the skid. Order is always preserved.

## Test plan
- Direct: index 0, write addr 0x0005 data 0xA5 → next cycle `rgn_we`=0001, `out_addr`=0x0005, `out_data`=0xA5; `ioctl_wait` stays 0.
- Handshake with stall: write addr 0x12010 data 0x3C, ack returned 7 cycles later → `rgn_req[2]` toggles at +1, `out_addr`=0x00010, `ioctl_wait` high for 7 cycles, low 1 cycle after ack.
- Skid/overflow: in WAIT_ACK, write 0x0E001 then 0x0E002 without ack → first byte held in skid, second sets `ovf`=1. After ack, `rgn_req[1]` toggles for 0x0E001 with `out_addr`=0x00001.
- Out of range: write 0x3A000 → `oob`=1, no strobe or toggle; index 1 writes → no effect at all.
- Loaded: download falls while ack is pending → `loaded` stays 0, then 1 one cycle after drain; a new download start clears `loaded`, `oob` and `ovf`.
- Async reset asserted in WAIT_ACK → all outputs 0 immediately, without waiting for a clock edge; after release, a direct write behaves as in the first scenario.
